// File: rtl/ccl_frame_sequencer.sv
// Frame-level sequencer for the connected-components labeler: streams pixels, flushes, flattens
// the merge table and reads out root labels. Optional obj_count output via CCL_SEQ_OBJ_COUNT_EN.
module ccl_frame_sequencer #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int LABEL_W   = 8,
    parameter int FLUSH_LEN = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_pix,
    output logic               lab_en,
    output logic [LABEL_W-1:0] lab_p,
    output logic [31:0]        lab_x,
    output logic [31:0]        lab_y,
    input  logic [LABEL_W-1:0] num_labels,
    output logic               mt_sel,
    output logic [LABEL_W-1:0] mt_raddr,
    input  logic [LABEL_W-1:0] mt_rdata,
    output logic               mt_wen,
    output logic [LABEL_W-1:0] mt_waddr,
    output logic [LABEL_W-1:0] mt_wdata,
    output logic               obj_valid,
    input  logic               obj_ready,
    output logic [LABEL_W-1:0] obj_id,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow
`ifdef CCL_SEQ_OBJ_COUNT_EN
    ,
    output logic [LABEL_W-1:0] obj_count
`endif
);

    typedef enum logic [3:0] {
        IDLE, STREAM, FLUSH, RES_RD, RES_CHK, RES_WR, RO_RD, RO_CHK, RO_OUT
    } state_t;

    state_t             state;
    logic [31:0]        x;
    logic [31:0]        y;
    logic [31:0]        fcnt;
    logic [LABEL_W-1:0] idx;
    logic [LABEL_W-1:0] nlab;
    logic [LABEL_W-1:0] raddr_q;
    logic               last_idx;
    logic               ro_next;

    assign last_idx = (idx == nlab - LABEL_W'(1));

    // The second read of a resolve step must hit the table the same cycle the first read returns,
    // so the chase address and the write data bypass the output registers.
    assign mt_raddr = (state == RES_CHK) ? mt_rdata : raddr_q;
    assign mt_wdata = mt_wen ? mt_rdata : '0;

    always_comb begin
        ro_next = 1'b0;
        if (state == RO_CHK && mt_rdata != idx)
            ro_next = 1'b1;
        if (state == RO_OUT && obj_ready)
            ro_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            fcnt       <= '0;
            idx        <= '0;
            nlab       <= '0;
            raddr_q    <= '0;
            in_ready   <= 1'b0;
            lab_en     <= 1'b0;
            lab_p      <= '0;
            lab_x      <= '0;
            lab_y      <= '0;
            mt_sel     <= 1'b0;
            mt_wen     <= 1'b0;
            mt_waddr   <= '0;
            obj_valid  <= 1'b0;
            obj_id     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
`ifdef CCL_SEQ_OBJ_COUNT_EN
            obj_count  <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            mt_wen     <= 1'b0;
            if (state != IDLE && num_labels == '1)
                overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= STREAM;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        x        <= '0;
                        y        <= '0;
                        overflow <= 1'b0;
`ifdef CCL_SEQ_OBJ_COUNT_EN
                        obj_count <= '0;
`endif
                    end
                end
                STREAM: begin
                    lab_en <= in_valid;
                    if (in_valid) begin
                        lab_p <= {{(LABEL_W-1){1'b0}}, in_pix};
                        lab_x <= x;
                        lab_y <= y;
                        if (x == 32'(IMG_W - 1)) begin
                            x <= '0;
                            if (y == 32'(IMG_H - 1)) begin
                                state    <= FLUSH;
                                in_ready <= 1'b0;
                                fcnt     <= '0;
                            end else begin
                                y <= y + 32'd1;
                            end
                        end else begin
                            x <= x + 32'd1;
                        end
                    end
                end
                FLUSH: begin
                    // Row IMG_H has the opposite parity of the last line, so the other merge stack drains.
                    if (fcnt == 32'(FLUSH_LEN)) begin
                        lab_en  <= 1'b0;
                        nlab    <= num_labels;
                        idx     <= LABEL_W'(1);
                        raddr_q <= LABEL_W'(1);
                        if (num_labels < LABEL_W'(2)) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            state  <= RES_RD;
                            mt_sel <= 1'b1;
                        end
                    end else begin
                        lab_en <= 1'b1;
                        lab_p  <= '0;
                        lab_x  <= fcnt;
                        lab_y  <= 32'(IMG_H);
                        fcnt   <= fcnt + 32'd1;
                    end
                end
                RES_RD: state <= RES_CHK;
                RES_CHK: begin
                    state    <= RES_WR;
                    mt_wen   <= 1'b1;
                    mt_waddr <= idx;
                end
                RES_WR: begin
                    // Parents are always lower labels and already flattened, so one hop reaches the root.
                    if (last_idx) begin
                        idx     <= LABEL_W'(1);
                        raddr_q <= LABEL_W'(1);
                        state   <= RO_RD;
                    end else begin
                        idx     <= idx + LABEL_W'(1);
                        raddr_q <= idx + LABEL_W'(1);
                        state   <= RES_RD;
                    end
                end
                RO_RD: state <= RO_CHK;
                RO_CHK: begin
                    if (mt_rdata == idx) begin
                        obj_id    <= idx;
                        obj_valid <= 1'b1;
                        state     <= RO_OUT;
                    end
                end
                RO_OUT: begin
                    if (obj_ready) begin
                        obj_valid <= 1'b0;
`ifdef CCL_SEQ_OBJ_COUNT_EN
                        obj_count <= obj_count + LABEL_W'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            if (ro_next) begin
                if (last_idx) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    mt_sel     <= 1'b0;
                    raddr_q    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    idx     <= idx + LABEL_W'(1);
                    raddr_q <= idx + LABEL_W'(1);
                    state   <= RO_RD;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccl_frame_sequencer.sv
// Directed bench for ccl_frame_sequencer on a 4x2 frame with a behavioural merge table.
module tb_ccl_frame_sequencer;

    localparam int IMG_W     = 4;
    localparam int IMG_H     = 2;
    localparam int LABEL_W   = 8;
    localparam int FLUSH_LEN = 8;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic               in_pix;
    logic               lab_en;
    logic [LABEL_W-1:0] lab_p;
    logic [31:0]        lab_x;
    logic [31:0]        lab_y;
    logic [LABEL_W-1:0] num_labels;
    logic               mt_sel;
    logic [LABEL_W-1:0] mt_raddr;
    logic [LABEL_W-1:0] mt_rdata;
    logic               mt_wen;
    logic [LABEL_W-1:0] mt_waddr;
    logic [LABEL_W-1:0] mt_wdata;
    logic               obj_valid;
    logic               obj_ready;
    logic [LABEL_W-1:0] obj_id;
    logic               busy;
    logic               frame_done;
    logic               overflow;
`ifdef CCL_SEQ_OBJ_COUNT_EN
    logic [LABEL_W-1:0] obj_count;
`endif

    ccl_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .LABEL_W(LABEL_W), .FLUSH_LEN(FLUSH_LEN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .lab_en(lab_en), .lab_p(lab_p), .lab_x(lab_x), .lab_y(lab_y),
        .num_labels(num_labels),
        .mt_sel(mt_sel), .mt_raddr(mt_raddr), .mt_rdata(mt_rdata),
        .mt_wen(mt_wen), .mt_waddr(mt_waddr), .mt_wdata(mt_wdata),
        .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_id(obj_id),
        .busy(busy), .frame_done(frame_done), .overflow(overflow)
`ifdef CCL_SEQ_OBJ_COUNT_EN
        , .obj_count(obj_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Merge table: synchronous read, writes from the bench preload port or the sequencer.
    logic [LABEL_W-1:0] mem [256];
    logic               tb_we;
    logic [LABEL_W-1:0] tb_wa;
    logic [LABEL_W-1:0] tb_wd;

    always @(posedge clk) begin
        mt_rdata <= mem[mt_raddr];
        if (tb_we)
            mem[tb_wa] <= tb_wd;
        else if (mt_wen)
            mem[mt_waddr] <= mt_wdata;
    end

    int compares;
    int fails;

    int beats_ok;
    int flush_ok;
    int gap_ok;
    int end_ok;
    int ready_drop_ok;
    logic [LABEL_W-1:0] ids [4];
    int n_obj;
    int done_seen;
    int done_cyc;
    int cnt_at_done;

    task automatic load_mt(input logic [LABEL_W-1:0] a, input logic [LABEL_W-1:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_stream(input logic [7:0] pix, input bit gaps);
        beats_ok = 0; flush_ok = 0; gap_ok = 0; end_ok = 0; ready_drop_ok = 0;
        for (int k = 0; k < IMG_W * IMG_H; k++) begin
            if (gaps && k > 0) begin
                in_valid = 1'b0;
                @(negedge clk);
                if (lab_en === 1'b0 && lab_x === 32'((k - 1) % IMG_W) && lab_y === 32'((k - 1) / IMG_W))
                    gap_ok++;
            end
            in_valid = 1'b1;
            in_pix   = pix[k];
            @(negedge clk);
            if (lab_en === 1'b1 && lab_x === 32'(k % IMG_W) && lab_y === 32'(k / IMG_W)
                && lab_p === {7'b0, pix[k]})
                beats_ok++;
        end
        in_valid = 1'b0;
        if (in_ready === 1'b0)
            ready_drop_ok = 1;
        for (int n = 0; n < FLUSH_LEN; n++) begin
            @(negedge clk);
            if (lab_en === 1'b1 && lab_x === 32'(n) && lab_y === 32'(IMG_H) && lab_p === 8'd0)
                flush_ok++;
        end
        @(negedge clk);
        if (lab_en === 1'b0)
            end_ok = 1;
    endtask

    task automatic collect();
        int c;
        c = 0; n_obj = 0; done_seen = 0; done_cyc = -1; cnt_at_done = -1;
        while (done_seen == 0 && c < 400) begin
            if (frame_done === 1'b1) begin
                done_seen = 1;
                done_cyc  = c;
`ifdef CCL_SEQ_OBJ_COUNT_EN
                cnt_at_done = int'(obj_count);
`endif
            end else begin
                if (obj_valid === 1'b1 && obj_ready === 1'b1) begin
                    if (n_obj < 4)
                        ids[n_obj] = obj_id;
                    n_obj++;
                end
                @(negedge clk);
                c++;
            end
        end
    endtask

    task automatic check_frame_basics(input string tag);
        compares++;
        if (beats_ok != IMG_W * IMG_H) begin
            fails++; $display("FAIL %s_pixels: good beats %0d want %0d", tag, beats_ok, IMG_W * IMG_H);
        end
        compares++;
        if (flush_ok != FLUSH_LEN || end_ok != 1) begin
            fails++; $display("FAIL %s_flush: good beats %0d end %0d want %0d end 1", tag, flush_ok, end_ok, FLUSH_LEN);
        end
        compares++;
        if (done_seen != 1) begin
            fails++; $display("FAIL %s_done: frame_done seen %0d want 1", tag, done_seen);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        compares++;
        if ({busy, in_ready, lab_en, mt_sel, mt_wen, obj_valid, frame_done, overflow} !== 8'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000000",
                {busy, in_ready, lab_en, mt_sel, mt_wen, obj_valid, frame_done, overflow});
        end
        compares++;
        if (lab_x !== 32'd0 || lab_y !== 32'd0 || lab_p !== 8'd0 || obj_id !== 8'd0 || mt_raddr !== 8'd0) begin
            fails++; $display("FAIL reset_data: x %0d y %0d p %0d id %0d raddr %0d want all 0",
                lab_x, lab_y, lab_p, obj_id, mt_raddr);
        end
    endtask

    task automatic test_empty_frame();
        num_labels = 8'd1;
        do_start();
        compares++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            fails++; $display("FAIL empty_start: busy %b in_ready %b want 1 1", busy, in_ready);
        end
        run_stream(8'h00, 1'b0);
        compares++;
        if (ready_drop_ok != 1) begin
            fails++; $display("FAIL empty_in_ready_drop: got %0d want 1", ready_drop_ok);
        end
        collect();
        check_frame_basics("empty");
        compares++;
        if (n_obj != 0 || done_cyc != 0) begin
            fails++; $display("FAIL empty_readout: objs %0d done_cyc %0d want 0 0", n_obj, done_cyc);
        end
        @(negedge clk);
        compares++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || mt_sel !== 1'b0) begin
            fails++; $display("FAIL empty_idle: busy %b done %b sel %b want 0 0 0", busy, frame_done, mt_sel);
        end
    endtask

    task automatic test_two_blobs();
        load_mt(8'd1, 8'd1);
        load_mt(8'd2, 8'd2);
        num_labels = 8'd3;
        do_start();
        run_stream(8'b1001_1001, 1'b0);
        collect();
        check_frame_basics("blobs");
        compares++;
        if (n_obj != 2 || ids[0] !== 8'd1 || ids[1] !== 8'd2) begin
            fails++; $display("FAIL blobs_ids: n %0d ids %0d,%0d want 2 ids 1,2", n_obj, ids[0], ids[1]);
        end
        compares++;
        if (done_cyc != 12) begin
            fails++; $display("FAIL blobs_latency: done after %0d cycles want 12", done_cyc);
        end
        compares++;
        if (mem[1] !== 8'd1 || mem[2] !== 8'd2) begin
            fails++; $display("FAIL blobs_table: mt1 %0d mt2 %0d want 1 2", mem[1], mem[2]);
        end
`ifdef CCL_SEQ_OBJ_COUNT_EN
        compares++;
        if (cnt_at_done != 2) begin
            fails++; $display("FAIL blobs_count: got %0d want 2", cnt_at_done);
        end
`endif
    endtask

    task automatic test_u_shape();
        load_mt(8'd1, 8'd1);
        load_mt(8'd2, 8'd1);
        num_labels = 8'd3;
        do_start();
        run_stream(8'b1111_1001, 1'b0);
        collect();
        check_frame_basics("ushape");
        compares++;
        if (n_obj != 1 || ids[0] !== 8'd1 || mem[2] !== 8'd1) begin
            fails++; $display("FAIL ushape_result: n %0d id %0d mt2 %0d want 1 1 1", n_obj, ids[0], mem[2]);
        end
    endtask

    task automatic test_chain();
        load_mt(8'd1, 8'd1);
        load_mt(8'd2, 8'd1);
        load_mt(8'd3, 8'd2);
        num_labels = 8'd4;
        do_start();
        run_stream(8'b0110_1011, 1'b0);
        collect();
        check_frame_basics("chain");
        compares++;
        if (mem[3] !== 8'd1 || mem[2] !== 8'd1 || mem[1] !== 8'd1) begin
            fails++; $display("FAIL chain_table: mt1 %0d mt2 %0d mt3 %0d want 1 1 1", mem[1], mem[2], mem[3]);
        end
        compares++;
        if (n_obj != 1 || ids[0] !== 8'd1) begin
            fails++; $display("FAIL chain_ids: n %0d id %0d want 1 1", n_obj, ids[0]);
        end
    endtask

    task automatic test_in_valid_gaps();
        num_labels = 8'd1;
        do_start();
        run_stream(8'b0101_1010, 1'b1);
        collect();
        check_frame_basics("gaps");
        compares++;
        if (gap_ok != IMG_W * IMG_H - 1) begin
            fails++; $display("FAIL gaps_hold: good gaps %0d want %0d", gap_ok, IMG_W * IMG_H - 1);
        end
    endtask

    task automatic test_obj_stall();
        int stable;
        int w;
        logic [LABEL_W-1:0] first;
        load_mt(8'd1, 8'd1);
        load_mt(8'd2, 8'd2);
        num_labels = 8'd3;
        obj_ready  = 1'b0;
        do_start();
        run_stream(8'b1000_0001, 1'b0);
        w = 0;
        while (obj_valid !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        first  = obj_id;
        stable = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (obj_valid === 1'b1 && obj_id === first)
                stable++;
        end
        compares++;
        if (w >= 100 || first !== 8'd1 || stable != 5) begin
            fails++; $display("FAIL stall_hold: wait %0d id %0d stable %0d want id 1 stable 5", w, first, stable);
        end
        obj_ready = 1'b1;
        collect();
        compares++;
        if (done_seen != 1 || n_obj != 2 || ids[0] !== 8'd1 || ids[1] !== 8'd2) begin
            fails++; $display("FAIL stall_ids: done %0d n %0d ids %0d,%0d want 1 2 ids 1,2",
                done_seen, n_obj, ids[0], ids[1]);
        end
    endtask

    task automatic test_overflow();
        num_labels = 8'd1;
        do_start();
        num_labels = 8'hFF;
        @(negedge clk);
        num_labels = 8'd1;
        run_stream(8'h00, 1'b0);
        collect();
        compares++;
        if (done_seen != 1 || overflow !== 1'b1) begin
            fails++; $display("FAIL overflow_sticky: done %0d overflow %b want 1 1", done_seen, overflow);
        end
        do_start();
        compares++;
        if (overflow !== 1'b0) begin
            fails++; $display("FAIL overflow_clear: got %b want 0", overflow);
        end
        run_stream(8'h00, 1'b0);
        collect();
    endtask

    task automatic test_reset_mid_resolve();
        int w;
        load_mt(8'd1, 8'd1);
        load_mt(8'd2, 8'd1);
        load_mt(8'd3, 8'd2);
        num_labels = 8'd4;
        do_start();
        run_stream(8'hFF, 1'b0);
        w = 0;
        while (mt_wen !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        compares++;
        if (w >= 50 || mt_sel !== 1'b1) begin
            fails++; $display("FAIL rst_reach_write: wait %0d sel %b want <50 1", w, mt_sel);
        end
        reset_n = 1'b0;
        @(negedge clk);
        compares++;
        if ({busy, mt_sel, mt_wen, obj_valid, in_ready, lab_en, frame_done} !== 7'b0) begin
            fails++; $display("FAIL rst_mid_outputs: got %b want 0000000",
                {busy, mt_sel, mt_wen, obj_valid, in_ready, lab_en, frame_done});
        end
        reset_n = 1'b1;
        load_mt(8'd1, 8'd1);
        load_mt(8'd2, 8'd2);
        num_labels = 8'd3;
        do_start();
        run_stream(8'b0011_1100, 1'b0);
        collect();
        check_frame_basics("rst_clean");
        compares++;
        if (n_obj != 2 || ids[0] !== 8'd1 || ids[1] !== 8'd2) begin
            fails++; $display("FAIL rst_clean_ids: n %0d ids %0d,%0d want 2 ids 1,2", n_obj, ids[0], ids[1]);
        end
`ifdef CCL_SEQ_OBJ_COUNT_EN
        compares++;
        if (cnt_at_done != 2) begin
            fails++; $display("FAIL rst_clean_count: got %0d want 2", cnt_at_done);
        end
`endif
    endtask

    initial begin
        compares   = 0;
        fails      = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_pix     = 1'b0;
        num_labels = '0;
        obj_ready  = 1'b1;
        tb_we      = 1'b0;
        tb_wa      = '0;
        tb_wd      = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_empty_frame();
        test_two_blobs();
        test_u_shape();
        test_chain();
        test_in_valid_gaps();
        test_obj_stall();
        test_overflow();
        test_reset_mid_resolve();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
